// File: rtl/ppg_window_stats_if.sv
// Sample input and window-statistics output bundle for ppg_window_stats.
// Signal prefixes are from the stats block's point of view (i_ into it, o_ out of it).
interface ppg_window_stats_if;
  logic        i_setting_done;
  logic        i_sample_valid;
  logic [7:0]  i_red_adc;
  logic [7:0]  i_ir_adc;
  logic [7:0]  o_red_ac;
  logic [7:0]  o_red_dc;
  logic [7:0]  o_ir_ac;
  logic [7:0]  o_ir_dc;
  logic        o_stats_valid;
  logic [15:0] o_beat_interval;
  logic        o_beat_valid;

  modport master (
    output i_setting_done, i_sample_valid, i_red_adc, i_ir_adc,
    input  o_red_ac, o_red_dc, o_ir_ac, o_ir_dc, o_stats_valid,
    input  o_beat_interval, o_beat_valid
  );

  modport slave (
    input  i_setting_done, i_sample_valid, i_red_adc, i_ir_adc,
    output o_red_ac, o_red_dc, o_ir_ac, o_ir_dc, o_stats_valid,
    output o_beat_interval, o_beat_valid
  );
endinterface

// File: rtl/ppg_window_stats.sv
// Per-window AC (max-min) and DC (mean) statistics of the RED/IR sample pairs.
// Define PPG_BEAT_DETECT_EN to compile in the IR beat-interval detector.
module ppg_window_stats #(
  parameter int WIN_LOG2 = 7,
  parameter int HYST     = 4
) (
  input logic               CLK,
  input logic               rst_n,
  ppg_window_stats_if.slave bus
);

  localparam int SUM_W = 8 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {WIN_LOG2{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_redMax, r_redMin, r_irMax, r_irMin;
  logic [SUM_W-1:0] r_redSum, r_irSum;
  logic [SUM_W-1:0] w_redExt, w_irExt;
  logic [7:0]       r_redAc, r_redDc, r_irAc, r_irDc;
  logic             r_statsValid;
  logic             w_accept, w_first, w_windowDone, w_publish;

  // In FINISH the counter is already zero, so its accepted sample opens the next window.
  assign w_accept     = bus.i_sample_valid & bus.i_setting_done & (r_state != IDLE);
  assign w_first      = (r_count == '0);
  assign w_windowDone = w_accept & (r_count == LAST_IDX);
  assign w_publish    = (r_state == FINISH) & bus.i_setting_done;
  assign w_redExt     = {{WIN_LOG2{1'b0}}, bus.i_red_adc};
  assign w_irExt      = {{WIN_LOG2{1'b0}}, bus.i_ir_adc};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (!bus.i_setting_done) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = ACCUM;
        ACCUM:   if (w_windowDone) w_nextState = FINISH;
        FINISH:  w_nextState = ACCUM;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_nextState == IDLE || r_state == IDLE || w_windowDone) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Dropping out to IDLE throws away a partial window; the first sample re-seeds anyway.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_redMax <= 8'h00;
      r_redMin <= 8'hFF;
      r_redSum <= '0;
      r_irMax  <= 8'h00;
      r_irMin  <= 8'hFF;
      r_irSum  <= '0;
    end else if (r_state == IDLE) begin
      r_redMax <= 8'h00;
      r_redMin <= 8'hFF;
      r_redSum <= '0;
      r_irMax  <= 8'h00;
      r_irMin  <= 8'hFF;
      r_irSum  <= '0;
    end else if (w_accept) begin
      if (w_first) begin
        r_redMax <= bus.i_red_adc;
        r_redMin <= bus.i_red_adc;
        r_redSum <= w_redExt;
        r_irMax  <= bus.i_ir_adc;
        r_irMin  <= bus.i_ir_adc;
        r_irSum  <= w_irExt;
      end else begin
        if (bus.i_red_adc > r_redMax) r_redMax <= bus.i_red_adc;
        if (bus.i_red_adc < r_redMin) r_redMin <= bus.i_red_adc;
        if (bus.i_ir_adc > r_irMax) r_irMax <= bus.i_ir_adc;
        if (bus.i_ir_adc < r_irMin) r_irMin <= bus.i_ir_adc;
        r_redSum <= r_redSum + w_redExt;
        r_irSum  <= r_irSum + w_irExt;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_redAc      <= 8'h00;
      r_redDc      <= 8'h00;
      r_irAc       <= 8'h00;
      r_irDc       <= 8'h00;
      r_statsValid <= 1'b0;
    end else begin
      r_statsValid <= 1'b0;
      if (w_publish) begin
        r_redAc      <= r_redMax - r_redMin;
        r_redDc      <= r_redSum[SUM_W-1:WIN_LOG2];
        r_irAc       <= r_irMax - r_irMin;
        r_irDc       <= r_irSum[SUM_W-1:WIN_LOG2];
        r_statsValid <= 1'b1;
      end
    end
  end

  assign bus.o_red_ac      = r_redAc;
  assign bus.o_red_dc      = r_redDc;
  assign bus.o_ir_ac       = r_irAc;
  assign bus.o_ir_dc       = r_irDc;
  assign bus.o_stats_valid = r_statsValid;

`ifdef PPG_BEAT_DETECT_EN
  localparam logic signed [9:0] HYST_S = 10'(HYST);

  logic               r_thrValid, r_armed, r_seenBeat, r_beatValid;
  logic [15:0]        r_intervalCnt, r_beatInterval;
  logic signed [9:0]  w_irS, w_thrS, w_hiThr, w_loThr;
  logic               w_arm, w_beat;

  // Ten-bit signed thresholds so thr-HYST below zero and thr+HYST above 255 never wrap.
  assign w_irS   = {2'b00, bus.i_ir_adc};
  assign w_thrS  = {2'b00, r_irDc};
  assign w_hiThr = w_thrS + HYST_S;
  assign w_loThr = w_thrS - HYST_S;
  assign w_arm   = w_accept & r_thrValid & (w_irS > w_hiThr);
  assign w_beat  = w_accept & r_thrValid & r_armed & (w_irS < w_loThr);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_thrValid     <= 1'b0;
      r_armed        <= 1'b0;
      r_seenBeat     <= 1'b0;
      r_intervalCnt  <= '0;
      r_beatInterval <= '0;
      r_beatValid    <= 1'b0;
    end else begin
      r_beatValid <= 1'b0;
      if (r_state == IDLE) begin
        r_thrValid    <= 1'b0;
        r_armed       <= 1'b0;
        r_seenBeat    <= 1'b0;
        r_intervalCnt <= '0;
      end else begin
        if (w_publish) r_thrValid <= 1'b1;
        if (w_beat) begin
          r_armed       <= 1'b0;
          r_seenBeat    <= 1'b1;
          r_intervalCnt <= '0;
          // The first beat after start-up has no previous beat to measure from.
          if (r_seenBeat) begin
            r_beatInterval <= (r_intervalCnt == 16'hFFFF) ? 16'hFFFF : r_intervalCnt + 16'd1;
            r_beatValid    <= 1'b1;
          end
        end else begin
          if (w_arm) r_armed <= 1'b1;
          if (w_accept && r_intervalCnt != 16'hFFFF) r_intervalCnt <= r_intervalCnt + 16'd1;
        end
      end
    end
  end

  assign bus.o_beat_interval = r_beatInterval;
  assign bus.o_beat_valid    = r_beatValid;
`else
  assign bus.o_beat_interval = 16'h0000;
  assign bus.o_beat_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ppg_window_stats.sv
// Directed bench for ppg_window_stats with WIN_LOG2=2, HYST=4; works with or
// without PPG_BEAT_DETECT_EN defined.
module tb_ppg_window_stats;

`ifdef PPG_BEAT_DETECT_EN
  localparam int EXP_PULSES = 4;
  localparam int EXP_FINAL  = 10;
`else
  localparam int EXP_PULSES = 0;
  localparam int EXP_FINAL  = 0;
`endif

  typedef struct {
    logic       sd;
    logic       v;
    logic [7:0] red;
    logic [7:0] ir;
    logic       expStats;
    logic       chk;
    logic [7:0] redAc;
    logic [7:0] redDc;
    logic [7:0] irAc;
    logic [7:0] irDc;
  } vec_t;

  logic        clk;
  logic        rstN;
  int          total;
  int          bad;
  int          beatPulses = 0;
  logic [15:0] intervals[$];
  vec_t        vecs[$];

  ppg_window_stats_if bus();

  ppg_window_stats #(.WIN_LOG2(2), .HYST(4)) dut (
    .CLK   (clk),
    .rst_n (rstN),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rstN && bus.o_beat_valid === 1'b1) begin
      beatPulses++;
      intervals.push_back(bus.o_beat_interval);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic applyStimulus(input logic sd, input logic v, input logic [7:0] red, input logic [7:0] ir);
    bus.i_setting_done = sd;
    bus.i_sample_valid = v;
    bus.i_red_adc      = red;
    bus.i_ir_adc       = ir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_red_ac"}, bus.o_red_ac, 0);
    checkOutput({tag, "_red_dc"}, bus.o_red_dc, 0);
    checkOutput({tag, "_ir_ac"}, bus.o_ir_ac, 0);
    checkOutput({tag, "_ir_dc"}, bus.o_ir_dc, 0);
    checkOutput({tag, "_stats_valid"}, bus.o_stats_valid, 0);
    checkOutput({tag, "_beat_interval"}, bus.o_beat_interval, 0);
    checkOutput({tag, "_beat_valid"}, bus.o_beat_valid, 0);
  endtask

  task automatic addRow(input logic sd, input logic v, input logic [7:0] red, input logic [7:0] ir,
                        input logic expStats);
    vec_t r;
    r.sd = sd; r.v = v; r.red = red; r.ir = ir;
    r.expStats = expStats; r.chk = 1'b0;
    r.redAc = 0; r.redDc = 0; r.irAc = 0; r.irDc = 0;
    vecs.push_back(r);
  endtask

  task automatic addChk(input logic sd, input logic v, input logic [7:0] red, input logic [7:0] ir,
                        input logic expStats, input logic [7:0] redAc, input logic [7:0] redDc,
                        input logic [7:0] irAc, input logic [7:0] irDc);
    vec_t r;
    r.sd = sd; r.v = v; r.red = red; r.ir = ir;
    r.expStats = expStats; r.chk = 1'b1;
    r.redAc = redAc; r.redDc = redDc; r.irAc = irAc; r.irDc = irDc;
    vecs.push_back(r);
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i].sd, vecs[i].v, vecs[i].red, vecs[i].ir);
      tick();
      checkOutput($sformatf("stats_valid[%0d]", i), bus.o_stats_valid, vecs[i].expStats);
      if (vecs[i].chk) begin
        checkOutput($sformatf("red_ac[%0d]", i), bus.o_red_ac, vecs[i].redAc);
        checkOutput($sformatf("red_dc[%0d]", i), bus.o_red_dc, vecs[i].redDc);
        checkOutput($sformatf("ir_ac[%0d]", i), bus.o_ir_ac, vecs[i].irAc);
        checkOutput($sformatf("ir_dc[%0d]", i), bus.o_ir_dc, vecs[i].irDc);
      end
    end
  endtask

  initial begin
    int segEnd;
    int segPost;
    int pulsesBefore;
    total = 0;
    bad   = 0;
    rstN  = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);

    // Window of 10,20,30,40 / IR 200: stats two edges after the 4th sample.
    addRow(1, 0, 0, 0, 0);
    addRow(1, 1, 10, 200, 0);
    addRow(1, 1, 20, 200, 0);
    addRow(1, 1, 30, 200, 0);
    addRow(1, 1, 40, 200, 0);
    addChk(1, 0, 0, 0, 1, 30, 25, 0, 200);
    addChk(1, 0, 0, 0, 0, 30, 25, 0, 200);
    // Eight back-to-back full-scale samples: pulses four cycles apart.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) addChk(1, 1, 255, 0, 1, 0, 255, 0, 0);
      else addRow(1, 1, 255, 0, 0);
    end
    addChk(1, 0, 0, 0, 1, 0, 255, 0, 0);
    addRow(1, 0, 0, 0, 0);
    // Aborted window must not leak into the next one.
    for (int i = 0; i < 3; i++) addRow(1, 1, 200, 10, 0);
    addRow(0, 0, 0, 0, 0);
    addChk(0, 0, 0, 0, 0, 0, 255, 0, 0);
    addRow(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addRow(1, 1, 50, 50, 0);
    addChk(1, 0, 0, 0, 1, 0, 50, 0, 50);
    addRow(1, 0, 0, 0, 0);
    // setting_done drops on the edge of the would-be last sample.
    for (int i = 0; i < 3; i++) addRow(1, 1, 60, 60, 0);
    addRow(0, 1, 60, 60, 0);
    addChk(0, 0, 0, 0, 0, 0, 50, 0, 50);
    addRow(1, 0, 0, 0, 0);
    addChk(1, 0, 0, 0, 0, 0, 50, 0, 50);
    // Gapped samples, DC truncation (257>>2=64, 405>>2=101).
    addRow(1, 1, 1, 100, 0);
    addRow(1, 0, 0, 0, 0);
    addRow(1, 1, 2, 100, 0);
    addRow(1, 0, 0, 0, 0);
    addRow(1, 1, 3, 101, 0);
    addRow(1, 1, 251, 104, 0);
    addChk(1, 0, 0, 0, 1, 250, 64, 4, 101);
    addRow(1, 0, 0, 0, 0);
    segEnd = vecs.size();
    // After a mid-window reset: only a full fresh window produces stats.
    addChk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addChk(1, 1, 8, 8, 0, 0, 0, 0, 0);
    addRow(1, 1, 8, 8, 0);
    addChk(1, 0, 0, 0, 1, 0, 8, 0, 8);
    segPost = vecs.size();

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rstN = 1'b1;
    tick();
    checkAllZero("after_release");

    runVectors(0, segEnd);

    applyStimulus(1'b1, 1'b1, 8'd9, 8'd9);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    pulsesBefore = beatPulses;
    rstN = 1'b0;
    #2;
    checkAllZero("mid_reset");
    tick();
    rstN = 1'b1;
    runVectors(segEnd, segPost);
    checkOutput("beat_pulses_after_reset", beatPulses - pulsesBefore, 0);

    // Beat test: every aligned IR window averages 100, so thr stays 100 (arm >104, beat <96).
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    tick();
    repeat (4) begin
      applyStimulus(1'b1, 1'b1, 8'd0, 8'd100);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (3) tick();
    checkOutput("beat_thr_ir_dc", bus.o_ir_dc, 100);
    pulsesBefore = beatPulses;
    intervals.delete();
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 10; s++) begin
        applyStimulus(1'b1, 1'b1, 8'd0, (s == 0) ? 8'd110 : ((s == 1) ? 8'd90 : 8'd100));
        tick();
      end
    end
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    repeat (2) tick();
    checkOutput("beat_pulses", beatPulses - pulsesBefore, EXP_PULSES);
    foreach (intervals[k]) checkOutput($sformatf("beat_interval_seq[%0d]", k), intervals[k], 10);
    checkOutput("beat_interval_final", bus.o_beat_interval, EXP_FINAL);
    checkOutput("beat_ir_dc_steady", bus.o_ir_dc, 100);
    checkOutput("beat_pulses_total", beatPulses, EXP_PULSES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppg_window_stats.md
# ppg_window_stats

Downstream signal-extraction stage of the pulse-oximeter front end. Consumes the per-channel RED/IR ADC samples produced by the LED/PGA controller once its setting search completes. Over fixed windows of 2^WIN_LOG2 sample pairs it reports per-channel AC (peak-to-peak) and DC (mean) values for the SpO2 ratio computation. Optionally, it also measures the beat-to-beat interval on the IR channel.

## Interface
- WIN_LOG2, 7, log2 of window length in sample pairs (legal 2..10)
- HYST, 4, beat-detector hysteresis in ADC LSBs (legal 0..63)
- CLK  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- setting_done  in  1  controller has finished the setting search; block runs only while high
- sample_valid  in  1  one-cycle strobe: red_adc/ir_adc hold a new sample pair
- red_adc  in  8  RED channel sample
- ir_adc  in  8  IR channel sample
- red_ac, red_dc, ir_ac, ir_dc  out  8 each  last completed window: max−min and sum>>WIN_LOG2
- stats_valid  out  1  one-cycle pulse when the four stats outputs update
- beat_interval  out  16  samples between the last two IR beats, saturating
- beat_valid  out  1  one-cycle pulse when beat_interval updates

## Operation
- FSM states: IDLE, ACCUM, FINISH.
  - IDLE → ACCUM when setting_done=1.
  - ACCUM → FINISH on the accepted sample that makes the count 2^WIN_LOG2.
  - FINISH → ACCUM unconditionally after 1 cycle.
  - Any state → IDLE when setting_done=0. The partial window is discarded and outputs hold their values.
- Sample acceptance: a sample is accepted when sample_valid=1 in ACCUM or FINISH. In FINISH, the accepted sample is the first sample of the new window.
- Per channel, ACCUM keeps:
  - max (init 0x00)
  - min (init 0xFF)
  - sum of width 8+WIN_LOG2 bits, which cannot overflow
  - The first sample of a window re-initialises the registers from the sample itself.
- FINISH registers the outputs:
  - ac = max−min (8-bit; never negative since max≥min)
  - dc = sum[WIN_LOG2+7:WIN_LOG2] (truncating)
  - stats_valid pulses.
- Sample counter: WIN_LOG2+1 bits, cleared on entry to FINISH and in IDLE.

## Timing
- Reset values: all outputs 0; FSM IDLE; max 0x00, min 0xFF, sums 0; beat state disarmed, threshold invalid.
- Stats latency: last window sample accepted at edge N. FINISH occupies edge N+1. Outputs change and stats_valid is high for the cycle after edge N+1.
- Back-to-back sample_valid every cycle is supported with no lost samples.
- setting_done falling at the same edge as the last sample: no stats_valid; go to IDLE.
- Reset mid-window: immediate return to reset values. No pulses are emitted.

## Configuration
- PPG_BEAT_DETECT_EN defined: beat detector is compiled in.
  - Threshold thr = ir_dc of the most recent completed window. Detector inactive until the first stats_valid after entering ACCUM.
  - Arm when an accepted ir_adc > thr+HYST.
  - Beat when armed and an accepted ir_adc < thr−HYST. Compare in 10-bit signed arithmetic; no wrap.
  - On a beat: disarm.
  - Interval counter: 16-bit, increments per accepted sample, saturates at 0xFFFF.
  - On a beat: beat_interval ← counter+1 (saturating) and beat_valid pulses next cycle; the counter clears.
  - The first beat after entering ACCUM only clears the counter and emits no pulse.
  - IDLE clears the counter and disarms the detector.
- PPG_BEAT_DETECT_EN undefined: no beat logic. beat_interval=0 and beat_valid=0 constantly.

## Test plan
- WIN_LOG2=2, setting_done=1; RED samples 10,20,30,40, IR 200 ×4, consecutive cycles → one stats_valid 2 cycles after the 4th sample; red_ac=30, red_dc=25, ir_ac=0, ir_dc=200.
- Same config, 8 contiguous samples, all RED=0xFF, IR=0x00 → two stats_valid pulses 4 cycles apart; red_dc=255, red_ac=0, ir_dc=0.
- Drop setting_done after 3 of 4 samples, reassert, feed 4 samples of 50 → single stats_valid; red_dc=50, red_ac=0 (no leak from aborted window).
- rst_n low for 1 cycle mid-window → all outputs 0, no stats_valid/beat_valid until a full new window completes.
- With PPG_BEAT_DETECT_EN, WIN_LOG2=2, HYST=4:
  - Sequence: first window IR 100 ×4 (thr=100), then IR cycling 110,90 with 10 samples per period.
  - Required: the first beat emits nothing; each later beat_valid shows beat_interval=10.
- Without PPG_BEAT_DETECT_EN, same stimulus → beat_valid never asserts, beat_interval stays 0.
